// File: rtl/alu_pkg.sv
// Shared ALU / multiply-divide definitions: op codes, funct3 decode, sequencer states.
package alu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITERS = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9,
    OP_OPB  = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_NEG_A = 3'd1,
    ST_NEG_B = 3'd2,
    ST_ITER  = 3'd3,
    ST_FIX   = 3'd4,
    ST_DONE  = 3'd5
  } mdu_state_e;

  typedef struct packed {
    alu_op_e           op;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
  } alu_req_t;

  // Divide keeps Q in lo and R in hi, so the result is always one of the two halves.
  function automatic logic [XLEN-1:0] mdu_select(input mdu_op_e op,
                                                 input logic [XLEN-1:0] hi,
                                                 input logic [XLEN-1:0] lo);
    logic [XLEN-1:0] res;
    case (op)
      MDU_MUL, MDU_DIV, MDU_DIVU: res = lo;
      default:                    res = hi;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu.sv
// Base 32-bit integer ALU, purely combinational; shared by the EX stage and the MDU sequencer.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_y_c
);

  always_comb begin
    o_y_c = '0;
    case (alu_op_e'(i_op))
      OP_ADD:  o_y_c = i_a + i_b;
      OP_SUB:  o_y_c = i_a - i_b;
      OP_SLL:  o_y_c = i_a << i_b[4:0];
      OP_SLT:  o_y_c = XLEN'($signed(i_a) < $signed(i_b));
      OP_SLTU: o_y_c = XLEN'(i_a < i_b);
      OP_XOR:  o_y_c = i_a ^ i_b;
      OP_SRL:  o_y_c = i_a >> i_b[4:0];
      OP_SRA:  o_y_c = $unsigned($signed(i_a) >>> i_b[4:0]);
      OP_OR:   o_y_c = i_a | i_b;
      OP_AND:  o_y_c = i_a & i_b;
      OP_OPB:  o_y_c = i_b;
      default: o_y_c = '0;
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer; every add/sub step goes through the shared ALU.
module mdu_seq
  import alu_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  input  logic            i_kill,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  mdu_state_e       r_state;
  mdu_op_e          r_op;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic             r_sa;
  logic             r_sb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [XLEN-1:0]  r_result;

  alu_req_t         w_req;
  logic [XLEN-1:0]  w_alu_y;
  logic             w_is_div;
  logic [XLEN:0]    w_s33;
  logic             w_carry;
  logic             w_ge;
  logic [XLEN-1:0]  w_hi_n;
  logic [XLEN-1:0]  w_lo_n;
  logic             w_last;
  logic             w_need_fix;
  logic [XLEN-1:0]  w_fix_x;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic             w_ovf;
  logic             w_special;
  logic [XLEN-1:0]  w_special_res;

  assign w_is_div = r_op[2];
  assign w_s33    = {r_hi, r_lo[XLEN-1]};
  assign w_last   = (r_cnt == CNT_W'(ITERS - 1));
  assign w_fix_x  = (r_op == MDU_DIV) ? r_lo : r_hi;

  // Accept-time decode: negative signed operands and the short-circuit divide cases.
  assign w_a_neg  = i_operand_a[XLEN-1] &
                    ((i_op == MDU_MULH) || (i_op == MDU_MULHSU) ||
                     (i_op == MDU_DIV)  || (i_op == MDU_REM));
  assign w_b_neg  = i_operand_b[XLEN-1] &
                    ((i_op == MDU_MULH) || (i_op == MDU_DIV) || (i_op == MDU_REM));
  assign w_b_zero = (i_operand_b == '0);
  assign w_ovf    = i_op[2] & ~i_op[0] & (i_operand_a == 32'h8000_0000) & (i_operand_b == '1);
  assign w_special = i_op[2] & (w_b_zero | w_ovf);
  assign w_special_res = w_b_zero ? (i_op[1] ? i_operand_a : '1)
                                  : (i_op[1] ? '0 : 32'h8000_0000);

  // Operand/op steering for the shared ALU, purely a function of the current state.
  always_comb begin
    w_req    = '0;
    w_req.op = OP_ADD;
    case (r_state)
      ST_NEG_A: begin
        w_req.op = OP_SUB;
        w_req.b  = r_a;
      end
      ST_NEG_B: begin
        w_req.op = OP_SUB;
        w_req.b  = r_b;
      end
      ST_ITER: begin
        if (w_is_div) begin
          w_req.op = OP_SUB;
          w_req.a  = w_s33[XLEN-1:0];
          w_req.b  = r_b;
        end else if (r_lo[0]) begin
          w_req.op = OP_ADD;
          w_req.a  = r_hi;
          w_req.b  = r_a;
        end else begin
          w_req.op = OP_OPB;
          w_req.b  = r_hi;
        end
      end
      ST_FIX: begin
        if (w_is_div) begin
          w_req.op = OP_SUB;
          w_req.b  = w_fix_x;
        end else if (r_lo == '0) begin
          w_req.op = OP_SUB;
          w_req.b  = r_hi;
        end else begin
          w_req.op = OP_XOR;
          w_req.a  = r_hi;
          w_req.b  = '1;
        end
      end
      default: w_req.op = OP_ADD;
    endcase
  end

  alu u_alu (
    .i_op  (w_req.op),
    .i_a   (w_req.a),
    .i_b   (w_req.b),
    .o_y_c (w_alu_y)
  );

  // One shift/add or restoring shift/sub step.
  always_comb begin
    w_carry = r_lo[0] & (w_alu_y < r_hi);
    w_ge    = w_s33[XLEN] | (w_s33[XLEN-1:0] >= r_b);
    if (w_is_div) begin
      w_hi_n = w_ge ? w_alu_y : w_s33[XLEN-1:0];
      w_lo_n = {r_lo[XLEN-2:0], w_ge};
    end else begin
      w_hi_n = {w_carry, w_alu_y[XLEN-1:1]};
      w_lo_n = {w_alu_y[0], r_lo[XLEN-1:1]};
    end
  end

  always_comb begin
    case (r_op)
      MDU_MULH, MDU_MULHSU, MDU_DIV: w_need_fix = r_sa ^ r_sb;
      MDU_REM:                       w_need_fix = r_sa;
      default:                       w_need_fix = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_op     <= MDU_MUL;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_kill && (r_state != ST_IDLE)) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start && !i_kill) begin
              r_op   <= mdu_op_e'(i_op);
              r_a    <= i_operand_a;
              r_b    <= i_operand_b;
              r_sa   <= w_a_neg;
              r_sb   <= w_b_neg;
              r_cnt  <= '0;
              r_hi   <= '0;
              r_lo   <= i_op[2] ? i_operand_a : i_operand_b;
              r_busy <= 1'b1;
              if (w_special) begin
                r_state  <= ST_DONE;
                r_done   <= 1'b1;
                r_result <= w_special_res;
              end else if (w_a_neg) begin
                r_state <= ST_NEG_A;
              end else if (w_b_neg) begin
                r_state <= ST_NEG_B;
              end else begin
                r_state <= ST_ITER;
              end
            end
          end
          ST_NEG_A: begin
            r_a <= w_alu_y;
            if (w_is_div) r_lo <= w_alu_y;
            r_state <= r_sb ? ST_NEG_B : ST_ITER;
          end
          ST_NEG_B: begin
            r_b <= w_alu_y;
            if (!w_is_div) r_lo <= w_alu_y;
            r_state <= ST_ITER;
          end
          ST_ITER: begin
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              if (w_need_fix) begin
                r_state <= ST_FIX;
              end else begin
                r_state  <= ST_DONE;
                r_done   <= 1'b1;
                r_result <= mdu_select(r_op, w_hi_n, w_lo_n);
              end
            end
          end
          ST_FIX: begin
            if (r_op == MDU_DIV) r_lo <= w_alu_y;
            else                 r_hi <= w_alu_y;
            r_state  <= ST_DONE;
            r_done   <= 1'b1;
            r_result <= w_alu_y;
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed and randomised checks of the iterative multiply/divide sequencer.
module tb_mdu_seq;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [2:0]  i_op;
  logic [31:0] i_operand_a;
  logic [31:0] i_operand_b;
  logic        i_kill;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;

  int checks = 0;
  int errors = 0;

  mdu_seq dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_op        (i_op),
    .i_operand_a (i_operand_a),
    .i_operand_b (i_operand_b),
    .i_kill      (i_kill),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_result    (o_result)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op once the unit is idle; returns result and accept-to-done latency (-1 on timeout).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    int w;
    w = 0;
    while (o_busy && w < 100) begin
      @(posedge i_clk); #1; w++;
    end
    @(negedge i_clk);
    i_op = op; i_operand_a = a; i_operand_b = b; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    lat = 1;
    while (!o_done && lat < 60) begin
      @(posedge i_clk); #1; lat++;
    end
    res = o_result;
    if (!o_done) lat = -1;
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic [31:0]        r;
    sp = '0;
    up = {32'b0, a} * {32'b0, b};
    case (op)
      3'd0: r = up[31:0];
      3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = sp[63:32]; end
      3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); r = sp[63:32]; end
      3'd3: r = up[63:32];
      3'd4: if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = 32'($signed(a) / $signed(b));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
            else r = 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = 32'($urandom_range(0, 40)) - 32'd20;
      1: case ($urandom_range(0, 4))
           0: v = 32'h0;
           1: v = 32'h1;
           2: v = 32'hFFFF_FFFF;
           3: v = 32'h8000_0000;
           default: v = 32'h7FFF_FFFF;
         endcase
      default: v = $urandom();
    endcase
    return v;
  endfunction

  logic [31:0] res;
  int          lat;
  int          cyc;
  logic        seen_done;

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_op = '0; i_operand_a = '0; i_operand_b = '0; i_kill = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_result", o_result, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    chk("mulhu_res", res, 32'hFFFF_FFFE);
    chk("mulhu_lat", 32'(lat), 32'd33);
    chk("done_busy", 32'(o_busy), 32'd1);
    @(posedge i_clk); #1;
    chk("done_pulse", 32'(o_done), 32'd0);
    chk("post_done_busy", 32'(o_busy), 32'd0);

    run_op(3'd0, 32'd7, 32'd6, res, lat);
    chk("mul_res", res, 32'd42);
    chk("mul_lat", 32'(lat), 32'd33);
    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, res, lat);
    chk("mulh_res", res, 32'hFFFF_FFFF);
    chk("mulh_lat", 32'(lat), 32'd35);

    run_op(3'd5, 32'd55, 32'd0, res, lat);
    chk("divu0_res", res, 32'hFFFF_FFFF);
    chk("divu0_lat", 32'(lat), 32'd1);
    run_op(3'd6, 32'h1234, 32'd0, res, lat);
    chk("rem0_res", res, 32'h1234);
    chk("rem0_lat", 32'(lat), 32'd1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    chk("divovf_res", res, 32'h8000_0000);
    chk("divovf_lat", 32'(lat), 32'd1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    chk("removf_res", res, 32'h0);
    chk("removf_lat", 32'(lat), 32'd1);

    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, res, lat);
    chk("div_res", res, 32'hFFFF_FFFD);
    chk("div_lat", 32'(lat), 32'd35);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, res, lat);
    chk("rem_res", res, 32'hFFFF_FFFF);
    chk("rem_lat", 32'(lat), 32'd35);
    run_op(3'd5, 32'd100, 32'd7, res, lat);
    chk("divu_res", res, 32'd14);
    chk("divu_lat", 32'(lat), 32'd33);
    run_op(3'd7, 32'd100, 32'd7, res, lat);
    chk("remu_res", res, 32'd2);
    chk("remu_lat", 32'(lat), 32'd33);

    // Kill during the tenth iteration of a DIVU.
    @(posedge i_clk); #1;
    @(negedge i_clk);
    i_op = 3'd5; i_operand_a = 32'd1000; i_operand_b = 32'd3; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (9) begin @(posedge i_clk); #1; end
    @(negedge i_clk);
    i_kill = 1'b1;
    @(posedge i_clk); #1;
    i_kill = 1'b0;
    chk("kill_busy", 32'(o_busy), 32'd0);
    chk("kill_done", 32'(o_done), 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge i_clk); #1;
      if (o_done) seen_done = 1'b1;
    end
    chk("kill_no_done", 32'(seen_done), 32'd0);
    chk("kill_result_held", o_result, 32'd2);
    run_op(3'd5, 32'd1000, 32'd3, res, lat);
    chk("restart_res", res, 32'd333);
    chk("restart_lat", 32'(lat), 32'd33);

    // Kill and start together while idle: nothing accepted.
    @(posedge i_clk); #1;
    @(negedge i_clk);
    i_op = 3'd0; i_operand_a = 32'd9; i_operand_b = 32'd9; i_start = 1'b1; i_kill = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_kill = 1'b0;
    chk("killstart_busy", 32'(o_busy), 32'd0);
    @(posedge i_clk); #1;
    chk("killstart_done", 32'(o_done), 32'd0);

    // Start pulsed while busy is ignored.
    @(negedge i_clk);
    i_op = 3'd0; i_operand_a = 32'd3; i_operand_b = 32'd4; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    cyc = 1;
    repeat (4) begin @(posedge i_clk); #1; cyc++; end
    @(negedge i_clk);
    i_op = 3'd5; i_operand_a = 32'd9; i_operand_b = 32'd0; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    cyc++;
    while (!o_done && cyc < 60) begin @(posedge i_clk); #1; cyc++; end
    chk("busy_start_res", o_result, 32'd12);
    chk("busy_start_lat", 32'(cyc), 32'd33);
    seen_done = 1'b0;
    repeat (5) begin
      @(posedge i_clk); #1;
      if (o_done) seen_done = 1'b1;
    end
    chk("busy_start_noqueue", 32'(seen_done), 32'd0);

    // Synchronous reset during iteration 20.
    @(negedge i_clk);
    i_op = 3'd3; i_operand_a = 32'hFFFF_FFFF; i_operand_b = 32'hFFFF_FFFF; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (19) begin @(posedge i_clk); #1; end
    @(negedge i_clk);
    i_rst = 1'b1; i_kill = 1'b1; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_kill = 1'b0; i_start = 1'b0;
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_done", 32'(o_done), 32'd0);
    chk("midrst_result", o_result, 32'd0);

    // Randomised regression against the arithmetic reference.
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      run_op(op, a, b, res, lat);
      chk("rand_done", 32'(lat > 0), 32'd1);
      chk($sformatf("rand_op%0d_%h_%h", op, a, b), res, ref_mdu(op, a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
